fib_seq_ctrl: RTL

Sequencing controller for the Fibonacci datapath: on a `start` request it seeds the two term registers, steps the adder/register pair once per accepted output, and streams a requested number of terms out over a valid/ready handshake. It owns the seed/advance/stop decisions that the free-running generator lacks. It also reports completion and arithmetic overflow. It sits between a host/command source and any downstream consumer of terms.

---
 rtl/fib_seq_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fib_seq_ctrl.sv
`default_nettype none
// fib_seq_ctrl: seeds, advances and stops a Fibonacci term stream over valid/ready.
// Optional macro FIB_SEQ_OVF_STOP_EN: end the run instead of presenting a wrapped term.
module fib_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  output logic             busy,
  output logic [WIDTH-1:0] term,
  output logic [CNT_W-1:0] term_idx,
  output logic             term_valid,
  input  logic             term_ready,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cur, cur_n;
  logic [WIDTH-1:0] nxt, nxt_n;
  logic             nxt_ovf, nxt_ovf_n;
  logic [CNT_W-1:0] remain, remain_n;
  logic [CNT_W-1:0] idx_n;
  logic             ovf_n;
  logic [WIDTH:0]   sum;

  assign sum  = {1'b0, cur} + {1'b0, nxt};
  assign term = cur;

  always_comb begin
    state_n   = state;
    cur_n     = cur;
    nxt_n     = nxt;
    nxt_ovf_n = nxt_ovf;
    remain_n  = remain;
    idx_n     = term_idx;
    ovf_n     = overflow;
    unique case (state)
      IDLE: begin
        if (start) begin
          ovf_n = 1'b0;
          if (n_terms != '0) begin
            state_n   = EMIT;
            cur_n     = '0;
            nxt_n     = WIDTH'(1);
            nxt_ovf_n = 1'b0;
            idx_n     = '0;
            remain_n  = n_terms;
          end else begin
            state_n = DONE;
          end
        end
      end
      EMIT: begin
        if (term_ready) begin
          remain_n = remain - CNT_W'(1);
          // The last term ends the run before any advance, so no wrap is recorded for it.
          if (remain == CNT_W'(1)) begin
            state_n = DONE;
          end
`ifdef FIB_SEQ_OVF_STOP_EN
          else if (nxt_ovf) begin
            state_n = DONE;
            ovf_n   = 1'b1;
          end
`endif
          else begin
            cur_n     = nxt;
            nxt_n     = sum[WIDTH-1:0];
            nxt_ovf_n = sum[WIDTH] | nxt_ovf;
            idx_n     = term_idx + CNT_W'(1);
            if (nxt_ovf) ovf_n = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so every output comes from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      nxt        <= '0;
      nxt_ovf    <= 1'b0;
      remain     <= '0;
      term_idx   <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
      term_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      nxt        <= nxt_n;
      nxt_ovf    <= nxt_ovf_n;
      remain     <= remain_n;
      term_idx   <= idx_n;
      overflow   <= ovf_n;
      busy       <= (state_n != IDLE);
      term_valid <= (state_n == EMIT);
      done       <= (state_n == DONE);
    end
  end

endmodule
`default_nettype wire
